sync_activity_monitor: RTL and testbench

SYNC_ACTIVITY_MONITOR -- requirements
Module: sync_activity_monitor

---
 rtl/sync_monitor_pkg.sv | 25 ++
 rtl/sync_activity_monitor_if.sv | 27 ++
 rtl/sync_channel_monitor.sv | 222 ++++++++++++++++++++++
 rtl/sync_activity_monitor.sv | 41 ++++
 tb/tb_sync_activity_monitor.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_monitor_pkg.sv
// Shared definitions for the sync activity monitor: per-channel FSM
// encoding, post-reset warm-up length and a small arithmetic helper.
package sync_monitor_pkg;

    // Per-channel acquisition state.
    typedef enum logic [1:0] {
        NO_SIGNAL = 2'd0,
        ACQUIRE   = 2'd1,
        LOCKED    = 2'd2
    } chan_state_t;

    // Cycles after reset release during which edge detection is suppressed,
    // so synchroniser flops filling up from reset never look like edges.
    localparam int WARMUP_CYCLES = 3;

    // Absolute difference of two unsigned values.
    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return b - a;
        end
    endfunction

endpackage

// File: rtl/sync_activity_monitor_if.sv
// Per-channel bundle between the top-level bus packing and one channel
// monitor: the raw sync input and the channel's status outputs.
interface sync_activity_monitor_if #(
    parameter int PERIOD_WIDTH = 24
);
    logic                    sync;
    logic                    present;
    logic                    locked;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    change;

    modport master (
        output sync,
        input  present,
        input  locked,
        input  period,
        input  change
    );

    modport slave (
        input  sync,
        output present,
        output locked,
        output period,
        output change
    );
endinterface

// File: rtl/sync_channel_monitor.sv
// One channel of the activity monitor: synchroniser, idle timeout,
// period measurement and the NO_SIGNAL/ACQUIRE/LOCKED lock FSM.
module sync_channel_monitor
    import sync_monitor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000000,
    parameter int PERIOD_WIDTH   = 24,
    parameter int LOCK_COUNT     = 4,
    parameter int TOLERANCE      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sync_activity_monitor_if.slave ch
);

    localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WARM_W  = $clog2(WARMUP_CYCLES + 1);

    localparam logic [IDLE_W-1:0]       IDLE_MAX    = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0]       IDLE_ZERO   = IDLE_W'(1'b0);
    localparam logic [IDLE_W-1:0]       IDLE_ONE    = IDLE_W'(1'b1);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX  = {PERIOD_WIDTH{1'b1}};
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ZERO = PERIOD_WIDTH'(1'b0);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE  = PERIOD_WIDTH'(1'b1);
    localparam logic [MATCH_W-1:0]      MATCH_LOCK  = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0]      MATCH_ZERO  = MATCH_W'(1'b0);
    localparam logic [MATCH_W-1:0]      MATCH_ONE   = MATCH_W'(1'b1);
    localparam logic [WARM_W-1:0]       WARM_DONE   = WARM_W'(WARMUP_CYCLES);
    localparam logic [WARM_W-1:0]       WARM_ZERO   = WARM_W'(1'b0);
    localparam logic [WARM_W-1:0]       WARM_ONE    = WARM_W'(1'b1);

    logic                    meta_r;
    logic                    sync_r;
    logic                    prev_r;
    logic [WARM_W-1:0]       warm_r;
    logic [IDLE_W-1:0]       idle_r;
    logic [IDLE_W-1:0]       idle_s;
    logic [PERIOD_WIDTH-1:0] pcnt_r;
    logic [PERIOD_WIDTH-1:0] pcnt_s;
    logic [PERIOD_WIDTH-1:0] cand_s;
    logic [PERIOD_WIDTH-1:0] ref_r;
    logic [PERIOD_WIDTH-1:0] ref_s;
    logic [PERIOD_WIDTH-1:0] period_r;
    logic [PERIOD_WIDTH-1:0] period_s;
    logic [MATCH_W-1:0]      match_cnt_r;
    logic [MATCH_W-1:0]      match_cnt_s;
    chan_state_t             state_r;
    chan_state_t             state_s;
    logic                    present_r;
    logic                    present_s;
    logic                    locked_r;
    logic                    locked_s;
    logic                    change_r;
    logic                    change_s;
    logic                    edge_en_s;
    logic                    activity_s;
    logic                    rise_s;
    logic                    timeout_s;
    logic                    period_match_s;

    // Two-flop synchroniser, edge-history flop and warm-up counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
            warm_r <= WARM_ZERO;
        end else begin
            meta_r <= ch.sync;
            sync_r <= meta_r;
            prev_r <= sync_r;
            if (warm_r != WARM_DONE) begin
                warm_r <= warm_r + WARM_ONE;
            end
        end
    end

    // Edge detection on the synchronised input; timeout loses to any edge.
    always_comb begin
        edge_en_s  = (warm_r == WARM_DONE);
        activity_s = edge_en_s & (sync_r ^ prev_r);
        rise_s     = edge_en_s & sync_r & ~prev_r;
        timeout_s  = (idle_r == IDLE_MAX) & ~activity_s;
    end

    // Saturating idle/period counters and the candidate period comparison.
    always_comb begin
        idle_s = idle_r;
        if (activity_s) begin
            idle_s = IDLE_ZERO;
        end else if (idle_r != IDLE_MAX) begin
            idle_s = idle_r + IDLE_ONE;
        end else begin
            idle_s = idle_r;
        end

        pcnt_s = pcnt_r;
        if (rise_s) begin
            pcnt_s = PERIOD_ZERO;
        end else if (pcnt_r != PERIOD_MAX) begin
            pcnt_s = pcnt_r + PERIOD_ONE;
        end else begin
            pcnt_s = pcnt_r;
        end

        // A saturated counter means the period overflowed and never matches.
        if (pcnt_r == PERIOD_MAX) begin
            cand_s = PERIOD_MAX;
        end else begin
            cand_s = pcnt_r + PERIOD_ONE;
        end
        period_match_s = (pcnt_r != PERIOD_MAX) &&
                         (abs_diff(32'(cand_s), 32'(ref_r)) <= 32'(TOLERANCE));
    end

    // Idle and period counter registers; idle starts saturated (absent).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_r <= IDLE_MAX;
            pcnt_r <= PERIOD_ZERO;
        end else begin
            idle_r <= idle_s;
            pcnt_r <= pcnt_s;
        end
    end

    // FSM state register together with its reference/match/period context.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= NO_SIGNAL;
            ref_r       <= PERIOD_ZERO;
            match_cnt_r <= MATCH_ZERO;
            period_r    <= PERIOD_ZERO;
        end else begin
            state_r     <= state_s;
            ref_r       <= ref_s;
            match_cnt_r <= match_cnt_s;
            period_r    <= period_s;
        end
    end

    // FSM next-state: timeout forces NO_SIGNAL, rising edges drive acquisition.
    always_comb begin
        state_s     = state_r;
        ref_s       = ref_r;
        match_cnt_s = match_cnt_r;
        period_s    = period_r;
        if (timeout_s) begin
            state_s     = NO_SIGNAL;
            ref_s       = PERIOD_ZERO;
            match_cnt_s = MATCH_ZERO;
            period_s    = PERIOD_ZERO;
        end else if (rise_s) begin
            case (state_r)
                NO_SIGNAL: begin
                    state_s     = ACQUIRE;
                    match_cnt_s = MATCH_ZERO;
                end
                ACQUIRE: begin
                    ref_s = cand_s;
                    if (match_cnt_r == MATCH_ZERO) begin
                        match_cnt_s = MATCH_ONE;
                    end else if (period_match_s) begin
                        match_cnt_s = match_cnt_r + MATCH_ONE;
                    end else begin
                        match_cnt_s = MATCH_ONE;
                    end
                    if (match_cnt_s == MATCH_LOCK) begin
                        state_s  = LOCKED;
                        period_s = cand_s;
                    end else begin
                        state_s = ACQUIRE;
                    end
                end
                LOCKED: begin
                    ref_s = cand_s;
                    if (period_match_s) begin
                        period_s = cand_s;
                    end else begin
                        state_s     = ACQUIRE;
                        match_cnt_s = MATCH_ONE;
                    end
                end
                default: begin
                    state_s     = NO_SIGNAL;
                    ref_s       = PERIOD_ZERO;
                    match_cnt_s = MATCH_ZERO;
                    period_s    = PERIOD_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM outputs: presence from the idle counter, lock from the next state.
    always_comb begin
        present_s = (idle_r < IDLE_MAX);
        locked_s  = (state_s == LOCKED);
        change_s  = (present_s != present_r) | (locked_s != locked_r);
    end

    // Registered status outputs, aligned so change pulses with the status edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            present_r <= 1'b0;
            locked_r  <= 1'b0;
            change_r  <= 1'b0;
        end else begin
            present_r <= present_s;
            locked_r  <= locked_s;
            change_r  <= change_s;
        end
    end

    assign ch.present = present_r;
    assign ch.locked  = locked_r;
    assign ch.period  = period_r;
    assign ch.change  = change_r;

endmodule

// File: rtl/sync_activity_monitor.sv
// Top level: one independent sync_channel_monitor per channel, with the
// per-channel status packed onto the output buses.
module sync_activity_monitor #(
    parameter int CHANNELS       = 2,
    parameter int TIMEOUT_CYCLES = 10000000,
    parameter int PERIOD_WIDTH   = 24,
    parameter int LOCK_COUNT     = 4,
    parameter int TOLERANCE      = 8
) (
    input  logic                             clk_50mhz_in,
    input  logic                             rst_in,
    input  logic [CHANNELS-1:0]              sync_in,
    output logic [CHANNELS-1:0]              signal_present_out,
    output logic [CHANNELS-1:0]              locked_out,
    output logic [CHANNELS*PERIOD_WIDTH-1:0] period_out,
    output logic [CHANNELS-1:0]              change_out
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sync_activity_monitor_if #(.PERIOD_WIDTH(PERIOD_WIDTH)) ch_bus ();

        assign ch_bus.sync = sync_in[i];

        sync_channel_monitor #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .PERIOD_WIDTH   (PERIOD_WIDTH),
            .LOCK_COUNT     (LOCK_COUNT),
            .TOLERANCE      (TOLERANCE)
        ) u_chan (
            .clk (clk_50mhz_in),
            .rst (rst_in),
            .ch  (ch_bus.slave)
        );

        assign signal_present_out[i]                   = ch_bus.present;
        assign locked_out[i]                           = ch_bus.locked;
        assign period_out[i*PERIOD_WIDTH +: PERIOD_WIDTH] = ch_bus.period;
        assign change_out[i]                           = ch_bus.change;
    end

endmodule

// File: tb/tb_sync_activity_monitor.sv
// Directed self-checking bench for sync_activity_monitor (2 channels,
// timeout 100, lock count 4, tolerance 2, 12-bit periods).
module tb_sync_activity_monitor;

    localparam int CHANNELS       = 2;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int PERIOD_WIDTH   = 12;
    localparam int LOCK_COUNT     = 4;
    localparam int TOLERANCE      = 2;

    logic                             clk = 1'b0;
    logic                             rst = 1'b0;
    logic [CHANNELS-1:0]              sync_bus;
    logic [CHANNELS-1:0]              present_bus;
    logic [CHANNELS-1:0]              locked_bus;
    logic [CHANNELS*PERIOD_WIDTH-1:0] period_bus;
    logic [CHANNELS-1:0]              change_bus;

    int tests_run    = 0;
    int tests_failed = 0;
    int chg_cnt0     = 0;
    int chg_cnt1     = 0;

    sync_activity_monitor_if #(.PERIOD_WIDTH(PERIOD_WIDTH)) ch0_if ();
    sync_activity_monitor_if #(.PERIOD_WIDTH(PERIOD_WIDTH)) ch1_if ();

    assign sync_bus       = {ch1_if.sync, ch0_if.sync};
    assign ch0_if.present = present_bus[0];
    assign ch1_if.present = present_bus[1];
    assign ch0_if.locked  = locked_bus[0];
    assign ch1_if.locked  = locked_bus[1];
    assign ch0_if.period  = period_bus[11:0];
    assign ch1_if.period  = period_bus[23:12];
    assign ch0_if.change  = change_bus[0];
    assign ch1_if.change  = change_bus[1];

    sync_activity_monitor #(
        .CHANNELS       (CHANNELS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .PERIOD_WIDTH   (PERIOD_WIDTH),
        .LOCK_COUNT     (LOCK_COUNT),
        .TOLERANCE      (TOLERANCE)
    ) dut (
        .clk_50mhz_in       (clk),
        .rst_in             (rst),
        .sync_in            (sync_bus),
        .signal_present_out (present_bus),
        .locked_out         (locked_bus),
        .period_out         (period_bus),
        .change_out         (change_bus)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Count change pulses per channel, sampled away from the active edge.
    always @(negedge clk) begin
        if (ch0_if.change === 1'b1) chg_cnt0 <= chg_cnt0 + 1;
        if (ch1_if.change === 1'b1) chg_cnt1 <= chg_cnt1 + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_sync(input int ch, input logic v);
        if (ch == 0) ch0_if.sync = v;
        else         ch1_if.sync = v;
    endtask

    task automatic wave_cycle(input int ch, input int hi, input int lo);
        set_sync(ch, 1'b1);
        step(hi);
        set_sync(ch, 1'b0);
        step(lo);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        ch0_if.sync = 1'b0;
        ch1_if.sync = 1'b0;
        step(2);
        rst = 1'b0;
        step(5);
    endtask

    // Reset with both inputs held high: nothing may ever report activity.
    task automatic test_reset();
        int base0;
        int base1;
        ch0_if.sync = 1'b1;
        ch1_if.sync = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if ((present_bus | locked_bus | change_bus) !== 2'b00 || period_bus !== 24'd0) begin
            tests_failed++;
            $display("FAIL reset_async: present=%b locked=%b change=%b period=%h, expected all 0",
                     present_bus, locked_bus, change_bus, period_bus);
        end
        step(3);
        base0 = chg_cnt0;
        base1 = chg_cnt1;
        rst = 1'b0;
        for (int c = 0; c < 300; c++) begin
            step(1);
            tests_run++;
            if ((present_bus | locked_bus | change_bus) !== 2'b00 || period_bus !== 24'd0) begin
                tests_failed++;
                $display("FAIL reset_held_11 cycle %0d: present=%b locked=%b change=%b period=%h, expected all 0",
                         c, present_bus, locked_bus, change_bus, period_bus);
            end
        end
        tests_run++;
        if ((chg_cnt0 - base0) + (chg_cnt1 - base1) !== 0) begin
            tests_failed++;
            $display("FAIL reset_change_count: got %0d pulses, expected 0",
                     (chg_cnt0 - base0) + (chg_cnt1 - base1));
        end
    endtask

    // Channel 0 square wave of period 40 from a fresh reset: presence and lock timing.
    task automatic lock_sequence(input string tag);
        int base0;
        base0 = chg_cnt0;
        set_sync(0, 1'b1);
        step(3);
        tests_run++;
        if (ch0_if.present !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_present_early: present=%b expected 0", tag, ch0_if.present);
        end
        step(1);
        tests_run++;
        if (ch0_if.present !== 1'b1 || ch0_if.change !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_present_rise: present=%b change=%b expected 1 1", tag, ch0_if.present, ch0_if.change);
        end
        step(1);
        tests_run++;
        if (ch0_if.change !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_change_width: change=%b expected 0", tag, ch0_if.change);
        end
        step(15);
        set_sync(0, 1'b0);
        step(20);
        repeat (3) wave_cycle(0, 20, 20);
        tests_run++;
        if (ch0_if.locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_locked_after4: locked=%b expected 0", tag, ch0_if.locked);
        end
        set_sync(0, 1'b1);
        step(2);
        tests_run++;
        if (ch0_if.locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_locked_early: locked=%b expected 0", tag, ch0_if.locked);
        end
        step(1);
        tests_run++;
        if (ch0_if.locked !== 1'b1 || ch0_if.change !== 1'b1 || ch0_if.period !== 12'd40) begin
            tests_failed++;
            $display("FAIL %s_lock: locked=%b change=%b period=%0d expected 1 1 40",
                     tag, ch0_if.locked, ch0_if.change, ch0_if.period);
        end
        step(17);
        set_sync(0, 1'b0);
        step(20);
        tests_run++;
        if (chg_cnt0 - base0 !== 2) begin
            tests_failed++;
            $display("FAIL %s_change_count: got %0d pulses, expected 2", tag, chg_cnt0 - base0);
        end
    endtask

    task automatic test_lock();
        do_reset();
        lock_sequence("lock");
    endtask

    // Jitter within tolerance holds lock; a step to period 46 drops and relocks.
    task automatic test_jitter();
        wave_cycle(0, 20, 19);
        wave_cycle(0, 20, 21);
        wave_cycle(0, 20, 19);
        wave_cycle(0, 20, 21);
        tests_run++;
        if (ch0_if.locked !== 1'b1 || ch0_if.period !== 12'd39) begin
            tests_failed++;
            $display("FAIL jitter_hold: locked=%b period=%0d expected 1 39", ch0_if.locked, ch0_if.period);
        end
        wave_cycle(0, 23, 23);
        tests_run++;
        if (ch0_if.locked !== 1'b1 || ch0_if.period !== 12'd41) begin
            tests_failed++;
            $display("FAIL jitter_edge41: locked=%b period=%0d expected 1 41", ch0_if.locked, ch0_if.period);
        end
        set_sync(0, 1'b1);
        step(2);
        tests_run++;
        if (ch0_if.locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL step_before_drop: locked=%b expected 1", ch0_if.locked);
        end
        step(1);
        tests_run++;
        if (ch0_if.locked !== 1'b0 || ch0_if.change !== 1'b1 || ch0_if.period !== 12'd41) begin
            tests_failed++;
            $display("FAIL step_drop: locked=%b change=%b period=%0d expected 0 1 41",
                     ch0_if.locked, ch0_if.change, ch0_if.period);
        end
        step(20);
        set_sync(0, 1'b0);
        step(23);
        wave_cycle(0, 23, 23);
        wave_cycle(0, 23, 23);
        set_sync(0, 1'b1);
        step(2);
        tests_run++;
        if (ch0_if.locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL step_relock_early: locked=%b expected 0", ch0_if.locked);
        end
        step(1);
        tests_run++;
        if (ch0_if.locked !== 1'b1 || ch0_if.change !== 1'b1 || ch0_if.period !== 12'd46) begin
            tests_failed++;
            $display("FAIL step_relock: locked=%b change=%b period=%0d expected 1 1 46",
                     ch0_if.locked, ch0_if.change, ch0_if.period);
        end
        step(20);
        set_sync(0, 1'b0);
        step(23);
    endtask

    // Input stops (last edge 23 cycles ago): both status bits fall at cycle 103.
    task automatic test_timeout();
        int base0;
        base0 = chg_cnt0;
        step(80);
        tests_run++;
        if (ch0_if.present !== 1'b1 || ch0_if.locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_early: present=%b locked=%b expected 1 1", ch0_if.present, ch0_if.locked);
        end
        step(1);
        tests_run++;
        if (ch0_if.present !== 1'b0 || ch0_if.locked !== 1'b0 || ch0_if.period !== 12'd0 ||
            ch0_if.change !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_fall: present=%b locked=%b period=%0d change=%b expected 0 0 0 1",
                     ch0_if.present, ch0_if.locked, ch0_if.period, ch0_if.change);
        end
        step(2);
        tests_run++;
        if (chg_cnt0 - base0 !== 1) begin
            tests_failed++;
            $display("FAIL timeout_change_count: got %0d pulses, expected 1", chg_cnt0 - base0);
        end
    endtask

    // Channel independence: ch1 idle while ch0 locks, then both locked.
    task automatic test_two_channels();
        int base1;
        do_reset();
        base1 = chg_cnt1;
        repeat (6) wave_cycle(0, 20, 20);
        tests_run++;
        if (ch0_if.locked !== 1'b1 || ch0_if.period !== 12'd40) begin
            tests_failed++;
            $display("FAIL two_ch0_alone: locked=%b period=%0d expected 1 40", ch0_if.locked, ch0_if.period);
        end
        tests_run++;
        if (ch1_if.present !== 1'b0 || ch1_if.locked !== 1'b0 || ch1_if.period !== 12'd0 ||
            chg_cnt1 - base1 !== 0) begin
            tests_failed++;
            $display("FAIL two_ch1_idle: present=%b locked=%b period=%0d pulses=%0d expected 0 0 0 0",
                     ch1_if.present, ch1_if.locked, ch1_if.period, chg_cnt1 - base1);
        end
        fork
            begin
                repeat (9) wave_cycle(0, 20, 20);
            end
            begin
                repeat (5) wave_cycle(1, 32, 32);
            end
        join
        tests_run++;
        if (ch0_if.locked !== 1'b1 || ch0_if.period !== 12'd40) begin
            tests_failed++;
            $display("FAIL two_ch0_both: locked=%b period=%0d expected 1 40", ch0_if.locked, ch0_if.period);
        end
        tests_run++;
        if (ch1_if.present !== 1'b1 || ch1_if.locked !== 1'b1 || ch1_if.period !== 12'd64) begin
            tests_failed++;
            $display("FAIL two_ch1_both: present=%b locked=%b period=%0d expected 1 1 64",
                     ch1_if.present, ch1_if.locked, ch1_if.period);
        end
    endtask

    // Reset pulse between clock edges while locked, then full reacquisition.
    task automatic test_reset_midop();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (present_bus !== 2'b00 || locked_bus !== 2'b00) begin
            tests_failed++;
            $display("FAIL midop_status: present=%b locked=%b expected 00 00", present_bus, locked_bus);
        end
        tests_run++;
        if (period_bus !== 24'd0 || change_bus !== 2'b00) begin
            tests_failed++;
            $display("FAIL midop_period: period=%h change=%b expected 0 00", period_bus, change_bus);
        end
        ch0_if.sync = 1'b0;
        ch1_if.sync = 1'b0;
        #1;
        rst = 1'b0;
        step(5);
        lock_sequence("relock");
    endtask

    initial begin
        ch0_if.sync = 1'b0;
        ch1_if.sync = 1'b0;
        test_reset();
        test_lock();
        test_jitter();
        test_timeout();
        test_two_channels();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
